// File: rtl/delay_report_sched_if.sv
// rtl/delay_report_sched_if.sv - report record valid/ready port of the window report scheduler
interface delay_report_sched_if #(
  parameter int LANE_W = 2
) ();
  logic              rpt_valid;
  logic              rpt_ready;
  logic [LANE_W-1:0] rpt_lane;
  logic [31:0]       rpt_avg;
  logic [31:0]       rpt_count;
  logic              rpt_zero;
  logic [15:0]       rpt_window;

  modport master (
    output rpt_valid,
    output rpt_lane,
    output rpt_avg,
    output rpt_count,
    output rpt_zero,
    output rpt_window,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_lane,
    input  rpt_avg,
    input  rpt_count,
    input  rpt_zero,
    input  rpt_window,
    output rpt_ready
  );
endinterface

// File: rtl/delay_report_sched.sv
// rtl/delay_report_sched.sv - per-window lane delay snapshot, serial average divider and report scheduler
module delay_report_sched #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    window_end,
  input  logic [32*NUM_LANES-1:0] delay_bus,
  input  logic [32*NUM_LANES-1:0] count_bus,
  delay_report_sched_if.master    rpt,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  state_t            state;
  state_t            state_next;

  logic [31:0]       snap_delay [NUM_LANES];
  logic [31:0]       snap_count [NUM_LANES];

  logic [LANE_W-1:0] lane_ptr;
  logic [15:0]       win_seq;

  // Divider: quot doubles as the dividend shift register, rem holds the
  // partial remainder between iterations (always < divisor, so 32 bits).
  logic [4:0]        iter;
  logic [31:0]       rem;
  logic [31:0]       quot;
  logic [31:0]       divisor;

  logic              is_last;
  logic              handshake;
  logic              accept;
  logic              drop;
  logic              do_start;

  logic [LANE_W-1:0] next_idx;
  logic [LANE_W-1:0] start_idx;
  logic [31:0]       start_delay;
  logic [31:0]       start_count;
  logic              start_zero;

  logic [32:0]       rem_shift;
  logic [32:0]       rem_sub;
  logic [32:0]       rem_step;
  logic              q_bit;
  logic [31:0]       quot_step;
  logic              unused_rem_msb;

  assign is_last   = (lane_ptr == LAST_LANE);
  assign handshake = (state == OUT) && rpt.rpt_ready;
  // A new window may only start when nothing of the previous one is left,
  // which includes the very edge at which the last record is taken.
  assign accept    = window_end && ((state == IDLE) || (handshake && is_last));
  assign drop      = window_end && !accept;
  assign do_start  = accept || (handshake && !is_last);

  assign rpt.rpt_valid = (state == OUT);
  assign rpt.rpt_lane  = lane_ptr;
  assign busy          = (state != IDLE);

  // Select the lane to start: lane 0 of the incoming bus on acceptance (the
  // snapshot is being written at that same edge), else the next snapshot lane.
  always_comb begin
    next_idx    = is_last ? '0 : lane_ptr + 1'b1;
    start_idx   = next_idx;
    start_delay = snap_delay[next_idx];
    start_count = snap_count[next_idx];
    if (accept) begin
      start_idx   = '0;
      start_delay = delay_bus[31:0];
      start_count = count_bus[31:0];
    end
    start_zero  = (start_count == 32'd0);
  end

  // One restoring-division step: shift in the next dividend bit, subtract the
  // divisor when it fits, and shift the resulting quotient bit in at the LSB.
  always_comb begin
    rem_shift      = {rem, quot[31]};
    rem_sub        = rem_shift - {1'b0, divisor};
    q_bit          = (rem_shift >= {1'b0, divisor});
    rem_step       = q_bit ? rem_sub : rem_shift;
    quot_step      = {quot[30:0], q_bit};
    unused_rem_msb = rem_step[32];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: lane start picks OUT directly for empty lanes, DIV otherwise.
  always_comb begin
    state_next = state;
    if (do_start) begin
      state_next = start_zero ? OUT : DIV;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        DIV:  if (iter == 5'd31) state_next = OUT;
        OUT:  if (handshake) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Snapshot every lane's totals only when a window is accepted, so the lanes
  // clearing afterwards cannot disturb the window being reported.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        snap_delay[i] <= '0;
        snap_count[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        snap_delay[i] <= delay_bus[32*i +: 32];
        snap_count[i] <= count_bus[32*i +: 32];
      end
    end
  end

  // Window numbering, lane start and the serial divider; record fields only
  // move at lane start or on the final divide step, never while OUT waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_ptr       <= '0;
      win_seq        <= '0;
      iter           <= '0;
      rem            <= '0;
      quot           <= '0;
      divisor        <= '0;
      rpt.rpt_avg    <= '0;
      rpt.rpt_count  <= '0;
      rpt.rpt_zero   <= 1'b0;
      rpt.rpt_window <= '0;
    end else begin
      if (accept) begin
        rpt.rpt_window <= win_seq;
        win_seq        <= win_seq + 16'd1;
      end
      if (do_start) begin
        lane_ptr      <= start_idx;
        rpt.rpt_count <= start_count;
        rpt.rpt_zero  <= start_zero;
        iter          <= '0;
        rem           <= '0;
        quot          <= start_delay;
        divisor       <= start_count;
        if (start_zero) begin
          rpt.rpt_avg <= '0;
        end
      end else if (state == DIV) begin
        rem  <= rem_step[31:0];
        quot <= quot_step;
        iter <= iter + 5'd1;
        if (iter == 5'd31) begin
          rpt.rpt_avg <= quot_step;
        end
      end
    end
  end

  // Sticky overrun flag; a drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_report_sched.sv
// tb/tb_delay_report_sched.sv - self-checking bench for delay_report_sched
module tb_delay_report_sched;
  localparam int NL = 4;
  localparam int LW = 2;

  typedef struct {
    logic [LW-1:0] lane;
    logic [31:0]   avg;
    logic [31:0]   count;
    logic          zero;
    logic [15:0]   win;
  } rec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             window_end = 1'b0;
  logic             clr_overrun = 1'b0;
  logic [32*NL-1:0] delay_bus = '0;
  logic [32*NL-1:0] count_bus = '0;
  logic             busy;
  logic             overrun;

  delay_report_sched_if #(.LANE_W(LW)) rif ();

  delay_report_sched #(.NUM_LANES(NL), .LANE_W(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .window_end  (window_end),
    .delay_bus   (delay_bus),
    .count_bus   (count_bus),
    .rpt         (rif),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: outstanding records of the current window, the edge at
  // which the head record must become visible, window numbering, overrun.
  rec_t        mq[$];
  rec_t        log_q[$];
  rec_t        r;
  longint      edge_n = 0;
  longint      valid_at = 0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_seq = '0;
  logic        ev, hs, acc, drp;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_ovr = 1'b0;
      m_seq = '0;
      chk("rst_valid", rif.rpt_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_lane", rif.rpt_lane, 0);
      chk("rst_avg", rif.rpt_avg, 0);
      chk("rst_count", rif.rpt_count, 0);
      chk("rst_zero", rif.rpt_zero, 0);
      chk("rst_window", rif.rpt_window, 0);
    end else begin
      ev = (mq.size() > 0) && (edge_n >= valid_at);
      chk("valid", rif.rpt_valid, ev);
      chk("busy", busy, mq.size() > 0);
      chk("overrun", overrun, m_ovr);
      if (ev) begin
        chk("lane", rif.rpt_lane, mq[0].lane);
        chk("avg", rif.rpt_avg, mq[0].avg);
        chk("count", rif.rpt_count, mq[0].count);
        chk("zero", rif.rpt_zero, mq[0].zero);
        chk("window", rif.rpt_window, mq[0].win);
      end
      hs  = ev && rif.rpt_ready;
      acc = window_end && ((mq.size() == 0) || (mq.size() == 1 && hs));
      drp = window_end && !acc;
      if (hs) begin
        r.lane  = rif.rpt_lane;
        r.avg   = rif.rpt_avg;
        r.count = rif.rpt_count;
        r.zero  = rif.rpt_zero;
        r.win   = rif.rpt_window;
        log_q.push_back(r);
        void'(mq.pop_front());
        if (mq.size() > 0) valid_at = edge_n + 1 + (mq[0].zero ? 0 : 32);
      end
      if (acc) begin
        for (int i = 0; i < NL; i++) begin
          r.lane  = LW'(i);
          r.count = count_bus[32*i +: 32];
          r.zero  = (r.count == 0);
          r.avg   = r.zero ? 32'd0 : delay_bus[32*i +: 32] / r.count;
          r.win   = m_seq;
          mq.push_back(r);
        end
        m_seq    = m_seq + 16'd1;
        valid_at = edge_n + 1 + (mq[0].zero ? 0 : 32);
      end
      if (drp) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      edge_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lanes(input logic [31:0] d0, d1, d2, d3, c0, c1, c2, c3);
    delay_bus = {d3, d2, d1, d0};
    count_bus = {c3, c2, c1, c0};
  endtask

  task automatic pulse_we();
    window_end = 1'b1;
    tick(1);
    window_end = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!rif.rpt_valid && cyc < 200) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      tick(1);
      k++;
    end
    chk(name, busy, 0);
  endtask

  task automatic chk_directed_window(input int base, input logic [15:0] w, input string tag);
    logic [31:0] exp_avg [4];
    logic        exp_zero [4];
    exp_avg  = '{32'd100, 32'd0, 32'd23, 32'hFFFF_FFFF};
    exp_zero = '{1'b0, 1'b1, 1'b0, 1'b0};
    chk({tag, "_nrec"}, log_q.size(), base + 4);
    if (log_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_lane"}, log_q[base+i].lane, i);
        chk({tag, "_avg"}, log_q[base+i].avg, exp_avg[i]);
        chk({tag, "_zero"}, log_q[base+i].zero, exp_zero[i]);
        chk({tag, "_win"}, log_q[base+i].win, w);
      end
    end
  endtask

  int          cyc;
  int          base;
  int          seen;
  logic [31:0] cap_avg;
  logic [31:0] cap_cnt;
  logic [31:0] c;

  initial begin
    rif.rpt_ready = 1'b1;
    tick(3);
    reset = 1'b1;

    // Idle after reset: nothing moves.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (rif.rpt_valid) seen++;
    end
    chk("idle_valid_rose", seen, 0);
    chk("idle_avg", rif.rpt_avg, 0);
    chk("idle_window", rif.rpt_window, 0);
    chk("idle_busy", busy, 0);

    // Directed window with the reference vectors, consumer always ready.
    set_lanes(32'd1000, 32'd0, 32'd70, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd3, 32'd1);
    pulse_we();
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    wait_valid(cyc);
    chk("lane0_latency", cyc, 32);
    wait_idle("w0_idle");
    chk_directed_window(0, 16'd0, "w0");

    // Backpressure: record must stay put while ready is low.
    rif.rpt_ready = 1'b0;
    set_lanes(32'd1000, 32'd0, 32'd70, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd3, 32'd1);
    pulse_we();
    set_lanes(32'd5, 32'd5, 32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1);
    wait_valid(cyc);
    cap_avg = rif.rpt_avg;
    cap_cnt = rif.rpt_count;
    tick(50);
    chk("bp_valid_held", rif.rpt_valid, 1);
    chk("bp_avg_held", rif.rpt_avg, cap_avg);
    chk("bp_count_held", rif.rpt_count, 32'd10);
    chk("bp_lane_held", rif.rpt_lane, 0);
    base = log_q.size();
    rif.rpt_ready = 1'b1;
    wait_idle("bp_idle");
    chk_directed_window(base, 16'd1, "bp");

    // Overrun: a second window_end during a window is dropped.
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    set_lanes(32'd1000, 32'd0, 32'd70, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd3, 32'd1);
    pulse_we();
    tick(19);
    set_lanes(32'd9, 32'd9, 32'd9, 32'd9, 32'd2, 32'd2, 32'd2, 32'd2);
    pulse_we();
    chk("ovr_set", overrun, 1);
    base = log_q.size();
    wait_idle("ovr_idle");
    chk_directed_window(base, 16'd0, "ovr");
    set_lanes(32'd1000, 32'd0, 32'd70, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd3, 32'd1);
    base = log_q.size();
    pulse_we();
    wait_idle("ovr_next_idle");
    chk_directed_window(base, 16'd1, "ovr_next");
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    chk("ovr_clear", overrun, 0);
    pulse_we();
    tick(5);
    window_end  = 1'b1;
    clr_overrun = 1'b1;
    tick(1);
    window_end  = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_set_beats_clear", overrun, 1);
    wait_idle("ovr_sc_idle");
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;

    // window_end landing on the last lane's handshake edge is accepted.
    set_lanes(32'd100, 32'd200, 32'd300, 32'd400, 32'd5, 32'd6, 32'd7, 32'd8);
    pulse_we();
    cyc = 0;
    while (!(rif.rpt_valid && rif.rpt_lane == 2'd3) && cyc < 300) begin
      tick(1);
      cyc++;
    end
    chk("bb_reach_last", rif.rpt_valid && rif.rpt_lane == 2'd3, 1);
    window_end = 1'b1;
    tick(1);
    window_end = 1'b0;
    chk("bb_overrun", overrun, 0);
    chk("bb_busy", busy, 1);
    wait_valid(cyc);
    chk("bb_lane", rif.rpt_lane, 0);
    chk("bb_window", rif.rpt_window, 16'd4);
    chk("bb_avg", rif.rpt_avg, 32'd20);
    wait_idle("bb_idle");

    // Reset during lane 2's division aborts the window.
    pulse_we();
    cyc = 0;
    while (!(busy && rif.rpt_lane == 2'd2 && !rif.rpt_valid) && cyc < 300) begin
      tick(1);
      cyc++;
    end
    chk("rd_in_div", busy && rif.rpt_lane == 2'd2, 1);
    tick(5);
    base = log_q.size();
    reset = 1'b0;
    #1;
    chk("rd_valid", rif.rpt_valid, 0);
    chk("rd_busy", busy, 0);
    chk("rd_lane", rif.rpt_lane, 0);
    chk("rd_avg", rif.rpt_avg, 0);
    chk("rd_count", rif.rpt_count, 0);
    chk("rd_window", rif.rpt_window, 0);
    tick(2);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (rif.rpt_valid) seen++;
    end
    chk("rd_no_record", seen, 0);
    chk("rd_no_log", log_q.size(), base);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int l = 0; l < NL; l++) begin
        case ($urandom_range(0, 3))
          0: c = 32'd0;
          1: c = $urandom_range(1, 7);
          2: c = $urandom;
          default: c = $urandom_range(1, 1000);
        endcase
        count_bus[32*l +: 32] = c;
        delay_bus[32*l +: 32] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 5000);
      end
      window_end    = ($urandom_range(0, 79) == 0);
      rif.rpt_ready = ($urandom_range(0, 3) != 0);
      clr_overrun   = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    window_end    = 1'b0;
    clr_overrun   = 1'b0;
    rif.rpt_ready = 1'b1;
    wait_idle("rand_idle");
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
